eth_rxbuf_ctrl: RTL and testbench

- Write-side sequencer and slot manager for the Ethernet RX frame buffer, a 16-bit port A / 64-bit port B dual-port RAM with byte write enables.
- Takes the MAC receive byte stream and writes each byte into a ring of fixed-size frame slots through buffer port A.
- Commits good frames with their byte length, and drops errored, oversize or no-room frames.
- Presents the oldest committed slot to the host side, which reads it through port B and releases it.

---
 rtl/eth_buf_pkg.sv | 13 +
 rtl/rxbuf_len_fifo.sv | 55 +++++
 rtl/eth_rxbuf_ctrl.sv | 110 +++++++++++
 tb/tb_eth_rxbuf_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_buf_pkg.sv
// Shared sizing and state encoding for the Ethernet RX frame buffer controller.
package eth_buf_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_AW   = 10;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);
  localparam int ADDR_W    = SLOT_W + SLOT_AW;
  localparam int LEN_W     = SLOT_AW + 2;
  localparam int MAX_BYTES = 2 * (2 ** SLOT_AW);

  typedef enum logic [1:0] {IDLE, RECV, DROP} rxbuf_state_e;

endpackage

// File: rtl/rxbuf_len_fifo.sv
// Committed-frame length FIFO: push/pop take effect at the clock edge, head and count are registered.
// Head reads zero while empty; a pop on empty and a push on full (without a pop) are ignored.
module rxbuf_len_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [PW:0]   count_n;
  logic          push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count != '0);
    push_ok  = push && ((count != FULL_CNT) || pop_ok);
    rd_ptr_n = rd_ptr + PW'(pop_ok);
    count_n  = count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_dat <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_ok);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      // The entry being pushed becomes the head when the FIFO drains to it this cycle.
      if (count_n == '0)
        head_dat <= '0;
      else if (push_ok && (rd_ptr_n == wr_ptr))
        head_dat <= push_dat;
      else
        head_dat <= mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/eth_rxbuf_ctrl.sv
// RX frame buffer write sequencer: one registered port-A write the cycle after each accepted byte.
// No rx backpressure; frames with no free slot, errors or oversize are dropped and counted.
module eth_rxbuf_ctrl
  import eth_buf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_last_i,
  input  logic               rx_err_i,
  output logic               buf_ena_o,
  output logic [1:0]         buf_wea_o,
  output logic [ADDR_W-1:0]  buf_addra_o,
  output logic [15:0]        buf_dina_o,
  output logic               slot_avail_o,
  output logic [SLOT_W-1:0]  rd_slot_o,
  output logic [LEN_W-1:0]   rd_len_o,
  input  logic               rd_release_i,
  output logic [SLOT_W:0]    pending_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  localparam logic [LEN_W-1:0]  MAX_IDX  = LEN_W'(MAX_BYTES);
  localparam logic [SLOT_W:0]   FULL_CNT = (SLOT_W+1)'(NUM_SLOTS);

  rxbuf_state_e      state, state_n;
  logic [LEN_W-1:0]  byte_idx, idx_n;
  logic [SLOT_W-1:0] wr_slot, rd_slot, rd_slot_n;
  logic [SLOT_W:0]   pend_n;
  logic              wr_en, commit, discard, release_ok;

  always_comb begin
    state_n = state;
    idx_n   = byte_idx;
    wr_en   = 1'b0;
    commit  = 1'b0;
    discard = 1'b0;
    if (rx_valid_i) begin
      // byte_idx is always 0 in IDLE, so a frame start shares the RECV write path.
      if ((state == IDLE && pending_o != FULL_CNT) || (state == RECV && byte_idx != MAX_IDX)) begin
        wr_en = 1'b1;
        if (rx_last_i) begin
          commit  = !rx_err_i;
          discard = rx_err_i;
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          state_n = RECV;
          idx_n   = byte_idx + LEN_W'(1);
        end
      end else if (rx_last_i) begin
        discard = 1'b1;
        state_n = IDLE;
        idx_n   = '0;
      end else begin
        state_n = DROP;
      end
    end
    release_ok = rd_release_i && (pending_o != '0);
    rd_slot_n  = rd_slot + SLOT_W'(release_ok);
    pend_n     = pending_o + (SLOT_W+1)'(commit) - (SLOT_W+1)'(release_ok);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      byte_idx     <= '0;
      wr_slot      <= '0;
      rd_slot      <= '0;
      buf_ena_o    <= 1'b0;
      buf_wea_o    <= '0;
      buf_addra_o  <= '0;
      buf_dina_o   <= '0;
      slot_avail_o <= 1'b0;
      rd_slot_o    <= '0;
      drop_cnt_o   <= '0;
    end else begin
      state     <= state_n;
      byte_idx  <= idx_n;
      buf_ena_o <= wr_en;
      buf_wea_o <= wr_en ? (byte_idx[0] ? 2'b10 : 2'b01) : 2'b00;
      if (wr_en) begin
        buf_addra_o <= {wr_slot, byte_idx[SLOT_AW:1]};
        buf_dina_o  <= {rx_data_i, rx_data_i};
      end
      if (commit) wr_slot <= wr_slot + SLOT_W'(1);
      rd_slot      <= rd_slot_n;
      slot_avail_o <= (pend_n != '0);
      rd_slot_o    <= (pend_n != '0) ? rd_slot_n : '0;
      if (discard && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end

  rxbuf_len_fifo #(
    .DEPTH (NUM_SLOTS),
    .W     (LEN_W)
  ) u_len_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (commit),
    .push_dat (byte_idx + LEN_W'(1)),
    .pop      (rd_release_i),
    .head_dat (rd_len_o),
    .count    (pending_o)
  );

endmodule

// File: tb/tb_eth_rxbuf_ctrl.sv
// Directed-vector bench for eth_rxbuf_ctrl: frames driven on the falling edge, outputs sampled there too.
module tb_eth_rxbuf_ctrl;
  import eth_buf_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              rx_valid_i, rx_last_i, rx_err_i, rd_release_i;
  logic [7:0]        rx_data_i;
  logic              buf_ena_o, slot_avail_o;
  logic [1:0]        buf_wea_o;
  logic [ADDR_W-1:0] buf_addra_o;
  logic [15:0]       buf_dina_o;
  logic [SLOT_W-1:0] rd_slot_o;
  logic [LEN_W-1:0]  rd_len_o;
  logic [SLOT_W:0]   pending_o;
  logic [15:0]       drop_cnt_o;

  always #5 clk_i = ~clk_i;

  eth_rxbuf_ctrl #(.CNT_W(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .rx_last_i    (rx_last_i),
    .rx_err_i     (rx_err_i),
    .buf_ena_o    (buf_ena_o),
    .buf_wea_o    (buf_wea_o),
    .buf_addra_o  (buf_addra_o),
    .buf_dina_o   (buf_dina_o),
    .slot_avail_o (slot_avail_o),
    .rd_slot_o    (rd_slot_o),
    .rd_len_o     (rd_len_o),
    .rd_release_i (rd_release_i),
    .pending_o    (pending_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  int n_vec = 0;
  int n_miss = 0;
  int wr_cnt, bad_cnt, first_addr, last_addr, last_wea, sum_wr, sum_bad;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives one frame; records every port-A write and counts those that differ from the expected slot layout.
  task automatic send_frame(input int len, input bit err, input int slot, input bit rel_last);
    logic [7:0] b;
    wr_cnt = 0; bad_cnt = 0; first_addr = -1; last_addr = -1; last_wea = -1;
    for (int k = 0; k < len; k++) begin
      b = 8'(k * 7 + len);
      rx_valid_i   = 1'b1;
      rx_data_i    = b;
      rx_last_i    = (k == len - 1);
      rx_err_i     = err && (k == len - 1);
      rd_release_i = rel_last && (k == len - 1);
      @(negedge clk_i);
      rd_release_i = 1'b0;
      if (buf_ena_o) begin
        if (wr_cnt == 0) first_addr = int'(buf_addra_o);
        wr_cnt++;
        last_addr = int'(buf_addra_o);
        last_wea  = int'(buf_wea_o);
        if (buf_addra_o != ADDR_W'(slot * (2 ** SLOT_AW) + k / 2) ||
            buf_wea_o != ((k % 2 == 1) ? 2'b10 : 2'b01) || buf_dina_o != {b, b})
          bad_cnt++;
      end
    end
    rx_valid_i = 1'b0; rx_last_i = 1'b0; rx_err_i = 1'b0;
  endtask

  task automatic release_slot();
    rd_release_i = 1'b1;
    @(negedge clk_i);
    rd_release_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    rx_valid_i = 1'b0; rx_last_i = 1'b0; rx_err_i = 1'b0; rd_release_i = 1'b0; rx_data_i = 8'h00;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    do_reset();
    chk("rst_avail", int'(slot_avail_o), 0);
    chk("rst_pend", int'(pending_o), 0);
    chk("rst_drop", int'(drop_cnt_o), 0);
    chk("rst_ena", int'(buf_ena_o), 0);
    chk("rst_len", int'(rd_len_o), 0);
    chk("rst_slot", int'(rd_slot_o), 0);

    // 64-byte frame into slot 0, then 61-byte frame into slot 1
    send_frame(64, 1'b0, 0, 1'b0);
    chk("f64_writes", wr_cnt, 64);
    chk("f64_bad", bad_cnt, 0);
    chk("f64_first", first_addr, 0);
    chk("f64_last_addr", last_addr, 31);
    chk("f64_last_wea", last_wea, 2);
    @(negedge clk_i);
    chk("f64_avail", int'(slot_avail_o), 1);
    chk("f64_slot", int'(rd_slot_o), 0);
    chk("f64_len", int'(rd_len_o), 64);
    chk("f64_pend", int'(pending_o), 1);
    chk("f64_ena_idle", int'(buf_ena_o), 0);
    release_slot();
    chk("rel_pend", int'(pending_o), 0);
    chk("rel_avail", int'(slot_avail_o), 0);
    chk("rel_len", int'(rd_len_o), 0);
    send_frame(61, 1'b0, 1, 1'b0);
    chk("f61_writes", wr_cnt, 61);
    chk("f61_bad", bad_cnt, 0);
    chk("f61_last_addr", last_addr, 1024 + 30);
    chk("f61_last_wea", last_wea, 1);
    @(negedge clk_i);
    chk("f61_len", int'(rd_len_o), 61);
    chk("f61_slot", int'(rd_slot_o), 1);

    // errored frame is written but discarded; slot 0 reused
    do_reset();
    send_frame(100, 1'b1, 0, 1'b0);
    chk("err_writes", wr_cnt, 100);
    chk("err_bad", bad_cnt, 0);
    @(negedge clk_i);
    chk("err_drop", int'(drop_cnt_o), 1);
    chk("err_pend", int'(pending_o), 0);
    chk("err_avail", int'(slot_avail_o), 0);
    send_frame(20, 1'b0, 0, 1'b0);
    chk("reuse_first", first_addr, 0);
    chk("reuse_writes", wr_cnt, 20);
    @(negedge clk_i);
    chk("reuse_len", int'(rd_len_o), 20);
    chk("reuse_pend", int'(pending_o), 1);

    // fill all slots, ninth frame dropped, release one, tenth lands in slot 0
    do_reset();
    sum_wr = 0; sum_bad = 0;
    for (int i = 0; i < 8; i++) begin
      send_frame(10 + i, 1'b0, i, 1'b0);
      sum_wr += wr_cnt;
      sum_bad += bad_cnt;
    end
    chk("fill_writes", sum_wr, 108);
    chk("fill_bad", sum_bad, 0);
    @(negedge clk_i);
    chk("fill_pend", int'(pending_o), 8);
    chk("fill_len", int'(rd_len_o), 10);
    chk("fill_drop", int'(drop_cnt_o), 0);
    send_frame(25, 1'b0, 0, 1'b0);
    chk("full_writes", wr_cnt, 0);
    @(negedge clk_i);
    chk("full_drop", int'(drop_cnt_o), 1);
    chk("full_pend", int'(pending_o), 8);
    release_slot();
    chk("full_rel_pend", int'(pending_o), 7);
    chk("full_rel_slot", int'(rd_slot_o), 1);
    chk("full_rel_len", int'(rd_len_o), 11);
    send_frame(30, 1'b0, 0, 1'b0);
    chk("wrap_writes", wr_cnt, 30);
    chk("wrap_first", first_addr, 0);
    chk("wrap_bad", bad_cnt, 0);
    @(negedge clk_i);
    chk("wrap_pend", int'(pending_o), 8);

    // oversize frame, then single-byte frame in the same slot
    do_reset();
    send_frame(2100, 1'b0, 0, 1'b0);
    chk("big_writes", wr_cnt, 2048);
    chk("big_bad", bad_cnt, 0);
    chk("big_last_addr", last_addr, 1023);
    @(negedge clk_i);
    chk("big_drop", int'(drop_cnt_o), 1);
    chk("big_pend", int'(pending_o), 0);
    send_frame(1, 1'b0, 0, 1'b0);
    chk("one_writes", wr_cnt, 1);
    chk("one_wea", last_wea, 1);
    chk("one_addr", first_addr, 0);
    @(negedge clk_i);
    chk("one_len", int'(rd_len_o), 1);
    chk("one_pend", int'(pending_o), 1);

    // release coincident with commit of a 40-byte frame in slot 1
    send_frame(40, 1'b0, 1, 1'b1);
    chk("co_writes", wr_cnt, 40);
    chk("co_bad", bad_cnt, 0);
    @(negedge clk_i);
    chk("co_pend", int'(pending_o), 1);
    chk("co_slot", int'(rd_slot_o), 1);
    chk("co_len", int'(rd_len_o), 40);
    chk("co_avail", int'(slot_avail_o), 1);

    // asynchronous reset in the middle of a frame
    for (int k = 0; k < 5; k++) begin
      rx_valid_i = 1'b1; rx_data_i = 8'(k + 3); rx_last_i = 1'b0;
      @(negedge clk_i);
    end
    chk("mid_ena_pre", int'(buf_ena_o), 1);
    #2 rst_i = 1'b1;
    rx_valid_i = 1'b0;
    #1;
    chk("arst_ena", int'(buf_ena_o), 0);
    chk("arst_wea", int'(buf_wea_o), 0);
    chk("arst_addr", int'(buf_addra_o), 0);
    chk("arst_din", int'(buf_dina_o), 0);
    chk("arst_avail", int'(slot_avail_o), 0);
    chk("arst_slot", int'(rd_slot_o), 0);
    chk("arst_len", int'(rd_len_o), 0);
    chk("arst_pend", int'(pending_o), 0);
    chk("arst_drop", int'(drop_cnt_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    send_frame(12, 1'b0, 0, 1'b0);
    chk("post_first", first_addr, 0);
    chk("post_writes", wr_cnt, 12);
    chk("post_bad", bad_cnt, 0);
    @(negedge clk_i);
    chk("post_slot", int'(rd_slot_o), 0);
    chk("post_len", int'(rd_len_o), 12);
    chk("post_pend", int'(pending_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
